// File: rtl/quad_decoder.sv
// quad_decoder: 2-FF sync, tick-rate glitch filter and
// 4x quadrature decode into a wrapping position count.
module quad_decoder #(
  parameter int CNT_WIDTH  = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 zero,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] position,
  output logic                 dir,
  output logic                 step,
  output logic                 err,
  output logic                 valid
);

  localparam logic [3:0] FL = 4'(FILTER_LEN);
  localparam logic [CNT_WIDTH-1:0] ONE = 1;

  typedef enum logic {S_INIT, S_RUN} state_e;
  state_e state_q, state_d;

  logic [1:0] s1_q, s2_q;
  logic [1:0] cand_q, cand_d;
  logic [3:0] mcnt_q, mcnt_d, mcnt_nx;
  logic [3:0] fa_q, fa_d, fb_q, fb_d;
  logic [1:0] filt_q, filt_d, prev_q, prev_d;
  logic [CNT_WIDTH-1:0] pos_q, pos_d;
  logic dir_q, dir_d;
  logic step_q, step_d;
  logic err_q, err_d;
  logic init_act, run_act, qual_hit;
  logic fwd, rev, ill;
  logic [1:0] idx_new, idx_old, delta;

  // returns {filtered bit, counter}
  function automatic logic [4:0] filt_step(
    logic s, logic f, logic [3:0] c
  );
    logic [3:0] n;
    n = 4'(c + 4'd1);
    if (s == f) return {f, 4'd0};
    if (n == FL) return {s, 4'd0};
    return {f, n};
  endfunction

  // 00,10,11,01 -> 0,1,2,3
  function automatic logic [1:0] gray_idx(logic [1:0] v);
    return {v[0], v[1] ^ v[0]};
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {enc_a, enc_b};
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && sample_en && qual_hit)
      state_d = S_RUN;
  end

  always_comb begin
    init_act = (state_q == S_INIT);
    run_act  = (state_q == S_RUN);
    valid    = run_act;
  end

  always_comb begin
    if (s2_q == cand_q) mcnt_nx = 4'(mcnt_q + 4'd1);
    else                mcnt_nx = 4'd1;
    qual_hit = (mcnt_nx == FL);
    cand_d = cand_q;
    mcnt_d = mcnt_q;
    if (init_act && sample_en) begin
      cand_d = s2_q;
      mcnt_d = mcnt_nx;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    if (init_act && sample_en && qual_hit) begin
      filt_d = s2_q;
    end else if (run_act && sample_en) begin
      {filt_d[1], fa_d} = filt_step(s2_q[1], filt_q[1], fa_q);
      {filt_d[0], fb_d} = filt_step(s2_q[0], filt_q[0], fb_q);
    end
    // prev tracks filt on entry so RUN starts with no change
    prev_d = run_act ? filt_q : filt_d;
  end

  always_comb begin
    idx_new = gray_idx(filt_q);
    idx_old = gray_idx(prev_q);
    delta   = 2'(idx_new - idx_old);
    fwd = run_act && (delta == 2'd1);
    rev = run_act && (delta == 2'd3);
    ill = run_act && (delta == 2'd2);
  end

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = ill | (err_q & ~err_clr);
    if (zero) begin
      pos_d = '0;
    end else begin
      unique case (1'b1)
        fwd: begin
          pos_d  = pos_q + ONE;
          dir_d  = 1'b1;
          step_d = 1'b1;
        end
        rev: begin
          pos_d  = pos_q - ONE;
          dir_d  = 1'b0;
          step_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cand_q <= '0;
      mcnt_q <= '0;
      fa_q   <= '0;
      fb_q   <= '0;
      filt_q <= '0;
      prev_q <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      mcnt_q <= mcnt_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign position = pos_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed scenarios plus random encoder
// traffic checked every cycle against a behavioural model.
module tb_quad_decoder;

  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, se, a, b, zr, clr;
  logic [15:0] pos;
  logic [3:0]  pos4;
  logic dir, step, err, valid;
  logic dir4, step4, err4, valid4;

  quad_decoder #(.CNT_WIDTH(16), .FILTER_LEN(FL)) dut (
    .clk_in(clk), .rst(rst), .sample_en(se),
    .enc_a(a), .enc_b(b), .zero(zr), .err_clr(clr),
    .position(pos), .dir(dir), .step(step),
    .err(err), .valid(valid)
  );

  quad_decoder #(.CNT_WIDTH(4), .FILTER_LEN(FL)) dut4 (
    .clk_in(clk), .rst(rst), .sample_en(se),
    .enc_a(a), .enc_b(b), .zero(zr), .err_clr(clr),
    .position(pos4), .dir(dir4), .step(step4),
    .err(err4), .valid(valid4)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_steps = 0;

  int m_pos;
  bit m_dir, m_step, m_err, m_valid;
  bit [1:0] dq [2];
  bit [1:0] m_cand, m_filt, m_prev;
  int m_run;
  int m_dis [2];

  bit [1:0] cur;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // forward successor in the {a,b} quadrature cycle
  function automatic bit [1:0] succ(bit [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit [1:0] pred(bit [1:0] v);
    for (int i = 0; i < 4; i++)
      if (succ(2'(i)) == v) return 2'(i);
    return 2'b00;
  endfunction

  task automatic model_edge();
    bit [1:0] sv;
    bit f, r, il;
    sv = dq[1];
    if (rst) begin
      m_pos = 0; m_dir = 0; m_step = 0; m_err = 0;
      m_valid = 0; m_cand = 0; m_run = 0;
      m_filt = 0; m_prev = 0;
      m_dis[0] = 0; m_dis[1] = 0;
      dq[0] = 0; dq[1] = 0;
      return;
    end
    f = 0; r = 0; il = 0;
    if (m_valid && m_filt != m_prev) begin
      if (m_filt == succ(m_prev))      f = 1;
      else if (m_prev == succ(m_filt)) r = 1;
      else                             il = 1;
    end
    m_step = 0;
    m_err = il || (m_err && !clr);
    if (zr) m_pos = 0;
    else if (f) begin
      m_pos = (m_pos + 1) & 16'hFFFF;
      m_dir = 1; m_step = 1;
    end else if (r) begin
      m_pos = (m_pos - 1) & 16'hFFFF;
      m_dir = 0; m_step = 1;
    end
    if (m_valid) begin
      m_prev = m_filt;
      if (se) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (sv[ch] != m_filt[ch]) begin
            m_dis[ch]++;
            if (m_dis[ch] == FL) begin
              m_filt[ch] = sv[ch];
              m_dis[ch] = 0;
            end
          end else m_dis[ch] = 0;
        end
      end
    end else if (se) begin
      if (sv == m_cand) m_run++;
      else begin
        m_cand = sv;
        m_run = 1;
      end
      if (m_run == FL) begin
        m_filt = m_cand;
        m_prev = m_cand;
        m_valid = 1;
      end
    end
    dq[1] = dq[0];
    dq[0] = {a, b};
  endtask

  task automatic clk1();
    @(posedge clk);
    model_edge();
    #1;
    chk("pos", pos, m_pos[15:0]);
    chk("pos4", pos4, m_pos[3:0]);
    chk("dir", dir, m_dir);
    chk("step", step, m_step);
    chk("err", err, m_err);
    chk("valid", valid, m_valid);
    chk("dir4", dir4, m_dir);
    chk("step4", step4, m_step);
    chk("err4", err4, m_err);
    chk("valid4", valid4, m_valid);
    if (step === 1'b1) n_steps++;
  endtask

  task automatic cyc(input int n);
    repeat (n) clk1();
  endtask

  task automatic go_fwd(input int n);
    repeat (n) begin
      cur = succ(cur);
      {a, b} = cur;
      cyc(8);
    end
  endtask

  task automatic go_rev(input int n);
    repeat (n) begin
      cur = pred(cur);
      {a, b} = cur;
      cyc(8);
    end
  endtask

  task automatic wait_valid(input int exp);
    int t = 0;
    while (valid !== 1'b1 && t < 40) begin
      clk1();
      t++;
    end
    chk("qual_lat", t, exp);
  endtask

  initial begin
    int s0;
    int seen;
    rst = 1; se = 1; zr = 0; clr = 0;
    cur = 2'b11;
    {a, b} = cur;
    cyc(2);
    chk("rst_pos", pos, 0);
    chk("rst_valid", valid, 0);
    rst = 0;
    s0 = n_steps;
    // sync flops start at 00, so a non-00 pin level
    // costs two extra ticks before it is seen
    wait_valid(2 + FL);
    chk("init_steps", n_steps - s0, 0);
    chk("init_err", err, 0);
    chk("init_pos", pos, 0);

    go_fwd(2);
    zr = 1; cyc(1); zr = 0;
    chk("zero_pos", pos, 0);
    s0 = n_steps;
    go_fwd(16);
    chk("fwd16_pos", pos, 16);
    chk("fwd16_dir", dir, 1);
    chk("fwd16_steps", n_steps - s0, 16);
    chk("fwd16_pos4", pos4, 0);
    go_rev(1);
    chk("rev_pos", pos, 15);
    chk("rev_dir", dir, 0);

    zr = 1; cyc(1); zr = 0;
    go_rev(1);
    chk("under_pos", pos, 16'hFFFF);
    chk("under_pos4", pos4, 4'hF);
    go_fwd(8);
    chk("pre_wrap4", pos4, 4'h7);
    go_fwd(1);
    chk("wrap4", pos4, 4'h8);
    chk("wrap_pos", pos, 16'h0008);

    s0 = n_steps;
    a = ~a; cyc(FL - 1); a = ~a; cyc(10);
    chk("glitch_short", n_steps - s0, 0);
    s0 = n_steps;
    a = ~a; cyc(FL); a = ~a; cyc(12);
    chk("glitch_long", n_steps - s0, 2);
    chk("glitch_pos", pos, 16'h0008);

    cur = cur ^ 2'b11;
    {a, b} = cur;
    cyc(8);
    chk("ill_err", err, 1);
    chk("ill_pos", pos, 16'h0008);
    clr = 1; cyc(1); clr = 0;
    chk("clr_err", err, 0);
    cyc(1);
    clr = 1;
    cur = cur ^ 2'b11;
    {a, b} = cur;
    seen = 0;
    repeat (10) begin
      clk1();
      if (err === 1'b1) seen = 1;
    end
    clr = 0;
    chk("ill_beats_clr", seen, 1);

    zr = 1;
    s0 = n_steps;
    go_fwd(1);
    zr = 0;
    chk("zero_count_steps", n_steps - s0, 0);
    chk("zero_count_pos", pos, 0);
    go_fwd(5);
    chk("pre_rst_pos", pos, 5);
    rst = 1; cyc(1);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_step", step, 0);
    rst = 0;
    wait_valid(cur == 2'b00 ? FL : 2 + FL);

    for (int seg = 0; seg < 400; seg++) begin
      int kind, hold, cont;
      bit [1:0] v;
      v = {a, b};
      kind = $urandom_range(0, 9);
      if (kind < 4)       v = succ(v);
      else if (kind < 7)  v = pred(v);
      else if (kind == 7) v = v ^ 2'b11;
      else                v = 2'($urandom_range(0, 3));
      {a, b} = v;
      hold = $urandom_range(1, 12);
      cont = $urandom_range(0, 1);
      for (int k = 0; k < hold; k++) begin
        se  = cont ? 1'b1 : 1'($urandom_range(0, 1));
        zr  = ($urandom_range(0, 39) == 0);
        clr = ($urandom_range(0, 19) == 0);
        rst = ($urandom_range(0, 499) == 0);
        clk1();
      end
    end
    rst = 0; se = 1; zr = 0; clr = 0;
    cyc(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
